updown_sweep_ctrl: RTL and testbench
====================================

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and rst are the clock and reset ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset; highest priority.
REQ-004 start  input  1  request a sweep run; sampled only in IDLE.
REQ-005 abort  input  1  terminate the run; return to IDLE.
REQ-006 hold  input  1  freeze q, state and sweep count for the cycle.
REQ-007 lo  input  4  lower sweep bound, unsigned; latched on accepted start.
REQ-008 hi  input  4  upper sweep bound, unsigned; latched on accepted start.
REQ-009 sweeps  input  4  number of lo->hi->lo sweeps; latched on accepted start.
REQ-010 q  output  4  shared up/down count value.
REQ-011 ctrl  output  1  count direction: 1 = up (state UP), 0 otherwise.
REQ-012 busy  output  1  high in states UP and DOWN.
REQ-013 done  output  1  one-cycle pulse, high only in state DONE.
REQ-014 err  output  1  one-cycle pulse on a rejected start.
REQ-015 sweep_cnt  output  4  completed sweeps in the current or last run.

Function
REQ-016 The FSM SHALL have states IDLE, UP, DOWN and DONE; all outputs are registered or decoded from the registered state.
REQ-017 Priority SHALL be rst > abort > hold > normal operation.
REQ-018 IDLE with start=1, lo<hi and sweeps!=0: latch lo/hi/sweeps, q<=lo, sweep_cnt<=0, go to UP.
REQ-019 IDLE with start=1 and (lo>=hi or sweeps==0): err=1 for the next cycle only; stay in IDLE; q and sweep_cnt unchanged.
REQ-020 UP: q<=q+1 each edge; on the edge where q+1==hi, q<=hi and go to DOWN.
REQ-021 DOWN: q<=q-1 each edge; on the edge where q-1==lo, q<=lo and sweep_cnt<=sweep_cnt+1.
REQ-022 On the same edge as REQ-021: go to DONE if sweep_cnt+1==sweeps, else go to UP.
REQ-023 DONE SHALL last exactly one cycle (done=1), then go to IDLE; q holds lo.
REQ-024 Each endpoint value (lo, hi) SHALL be presented for exactly one cycle per turn; hi=lo+1 is legal.
REQ-025 Because lo<hi is enforced, q SHALL never wrap 15->0 or 0->15.
REQ-026 start SHALL be ignored in UP, DOWN and DONE.
REQ-027 abort in UP or DOWN: go to IDLE on the next edge; q and sweep_cnt hold; done is not asserted.
REQ-028 abort in IDLE or DONE: no effect beyond DONE's normal exit to IDLE.
REQ-029 hold=1 in UP or DOWN: q, state and sweep_cnt unchanged; ctrl and busy keep their values.
REQ-030 Abort SHALL take precedence when abort and hold are asserted together.

Reset
REQ-031 When rst=1 at a clock edge, on that edge: state<=IDLE, q<=0, ctrl<=0, busy<=0, done<=0, err<=0, sweep_cnt<=0, latched bounds<=0.
REQ-032 Reset mid-run SHALL discard the run without asserting done.

Verification
REQ-033 lo=2, hi=5, sweeps=1, start pulse -> q = 2,3,4,5,4,3,2 on successive edges; ctrl=1 for 2,3,4 and 0 from 5 onward.
REQ-034 Continuing REQ-033 -> done=1 for exactly one cycle immediately after q returns to 2; sweep_cnt=1; then IDLE.
REQ-035 lo=0, hi=15, sweeps=2 -> two full 0..15..0 sweeps with no wrap; done one cycle after the second return to 0; sweep_cnt=2.
REQ-036 start with lo=7, hi=7, and separately with sweeps=0 -> err one-cycle pulse each time; busy stays 0; q unchanged.
REQ-037 hold high 3 cycles while q=4 in UP -> q stays 4 for those cycles, then resumes 5; abort while q=3 in DOWN -> IDLE, q=3, no done.
REQ-038 rst asserted mid-sweep with start held high -> all outputs 0 on the next edge; start accepted on the first edge after rst deasserts.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: counts q from lo up to hi and back down to lo,
// repeating for a requested number of sweeps, with abort and hold controls.
module updown_sweep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic [3:0] sweeps,
    output logic [3:0] q,
    output logic       ctrl,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] sweep_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] q_q, q_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] lo_q, lo_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] sweeps_q, sweeps_d;
    logic       err_q, err_d;

    logic [3:0] q_inc, q_dec, cnt_inc;

    // lo < hi is enforced at start, so these never wrap while in UP/DOWN.
    assign q_inc   = q_q + 4'd1;
    assign q_dec   = q_q - 4'd1;
    assign cnt_inc = cnt_q + 4'd1;

    // Next-state and datapath update; every target defaults to its held value.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal -- no latches.
        state_d  = state_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        sweeps_d = sweeps_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((lo < hi) && (sweeps != 4'd0)) begin
                        lo_d     = lo;
                        hi_d     = hi;
                        sweeps_d = sweeps;
                        q_d      = lo;
                        cnt_d    = 4'd0;
                        state_d  = S_UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    q_d = q_inc;
                    if (q_inc == hi_q) begin
                        state_d = S_DOWN;
                    end
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    q_d = q_dec;
                    if (q_dec == lo_q) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == sweeps_q) ? S_DONE : S_UP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            q_q      <= 4'd0;
            cnt_q    <= 4'd0;
            lo_q     <= 4'd0;
            hi_q     <= 4'd0;
            sweeps_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            sweeps_q <= sweeps_d;
            err_q    <= err_d;
        end
    end

    // Status outputs decoded from the registered state.
    assign q         = q_q;
    assign sweep_cnt = cnt_q;
    assign err       = err_q;
    assign ctrl      = (state_q == S_UP);
    assign busy      = (state_q == S_UP) || (state_q == S_DOWN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: the stimulus process pushes the
// hand-derived output expected after each edge; a monitor pops and compares.
module tb_updown_sweep_ctrl;

    typedef struct packed {
        logic [3:0] q;
        logic       ctrl;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] cnt;
    } outs_t;

    typedef struct {
        outs_t v;
        string tag;
    } exp_t;

    localparam int ST_IDLE = 0;
    localparam int ST_UP   = 1;
    localparam int ST_DOWN = 2;
    localparam int ST_DONE = 3;

    logic       clk = 1'b0;
    logic       rst, start, abort, hold;
    logic [3:0] lo, hi, sweeps;
    logic [3:0] q, sweep_cnt;
    logic       ctrl, busy, done, err;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    updown_sweep_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .lo        (lo),
        .hi        (hi),
        .sweeps    (sweeps),
        .q         (q),
        .ctrl      (ctrl),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt)
    );

    always #5 clk = ~clk;

    // Expected output word from q, a state code, sweep count and err.
    function automatic outs_t mk(input int qv, input int st, input int cv, input bit ev = 1'b0);
        outs_t o;
        o.q    = 4'(qv);
        o.ctrl = (st == ST_UP);
        o.busy = (st == ST_UP) || (st == ST_DOWN);
        o.done = (st == ST_DONE);
        o.err  = ev;
        o.cnt  = 4'(cv);
        return o;
    endfunction

    task automatic check(input string tag, input outs_t act, input outs_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got q=%0d ctrl=%b busy=%b done=%b err=%b cnt=%0d, expected q=%0d ctrl=%b busy=%b done=%b err=%b cnt=%0d",
                     tag, act.q, act.ctrl, act.busy, act.done, act.err, act.cnt,
                     req.q, req.ctrl, req.busy, req.done, req.err, req.cnt);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            outs_t act;
            e = exp_q.pop_front();
            act = '{q: q, ctrl: ctrl, busy: busy, done: done, err: err, cnt: sweep_cnt};
            check(e.tag, act, e.v);
        end
    end

    // One clock of stimulus plus the outputs expected after the next edge.
    task automatic cyc(input bit r, input bit s, input bit a, input bit h,
                       input int l, input int hh, input int sw,
                       input outs_t e, input string tag);
        exp_t x;
        @(negedge clk);
        #1;
        rst    = r;
        start  = s;
        abort  = a;
        hold   = h;
        lo     = 4'(l);
        hi     = 4'(hh);
        sweeps = 4'(sw);
        x.v    = e;
        x.tag  = tag;
        exp_q.push_back(x);
    endtask

    task automatic nop(input outs_t e, input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, e, tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
        lo = 4'd0; hi = 4'd0; sweeps = 4'd0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, mk(0, ST_IDLE, 0), "reset");
        nop(mk(0, ST_IDLE, 0), "idle_after_reset");

        // lo=2 hi=5 one sweep
        cyc(0, 1, 0, 0, 2, 5, 1, mk(2, ST_UP, 0), "s1_start");
        nop(mk(3, ST_UP, 0), "s1_q3");
        nop(mk(4, ST_UP, 0), "s1_q4");
        nop(mk(5, ST_DOWN, 0), "s1_q5");
        nop(mk(4, ST_DOWN, 0), "s1_q4d");
        nop(mk(3, ST_DOWN, 0), "s1_q3d");
        nop(mk(2, ST_DONE, 1), "s1_done");
        nop(mk(2, ST_IDLE, 1), "s1_idle");

        // Rejected starts: lo==hi, then sweeps==0
        cyc(0, 1, 0, 0, 7, 7, 1, mk(2, ST_IDLE, 1, 1'b1), "err_lo_eq_hi");
        nop(mk(2, ST_IDLE, 1), "err_pulse_end1");
        cyc(0, 1, 0, 0, 1, 3, 0, mk(2, ST_IDLE, 1, 1'b1), "err_sweeps0");
        nop(mk(2, ST_IDLE, 1), "err_pulse_end2");

        // Full range, two sweeps, no wrap
        cyc(0, 1, 0, 0, 0, 15, 2, mk(0, ST_UP, 0), "full_start");
        for (int s = 0; s < 2; s++) begin
            for (int v = 1; v <= 14; v++) nop(mk(v, ST_UP, s), "full_up");
            nop(mk(15, ST_DOWN, s), "full_top");
            for (int v = 14; v >= 1; v--) nop(mk(v, ST_DOWN, s), "full_down");
            if (s == 0) nop(mk(0, ST_UP, 1), "full_turn");
            else        nop(mk(0, ST_DONE, 2), "full_done");
        end
        nop(mk(0, ST_IDLE, 2), "full_idle");

        // Hold in UP, start ignored while busy, abort in DOWN
        cyc(0, 1, 0, 0, 2, 6, 1, mk(2, ST_UP, 0), "ha_start");
        cyc(0, 1, 0, 0, 9, 12, 3, mk(3, ST_UP, 0), "ha_start_ignored");
        nop(mk(4, ST_UP, 0), "ha_q4");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, mk(4, ST_UP, 0), "ha_hold");
        nop(mk(5, ST_UP, 0), "ha_resume");
        nop(mk(6, ST_DOWN, 0), "ha_top");
        nop(mk(5, ST_DOWN, 0), "ha_q5d");
        nop(mk(4, ST_DOWN, 0), "ha_q4d");
        nop(mk(3, ST_DOWN, 0), "ha_q3d");
        cyc(0, 0, 1, 0, 0, 0, 0, mk(3, ST_IDLE, 0), "ha_abort");
        nop(mk(3, ST_IDLE, 0), "ha_no_done");

        // Abort wins over hold
        cyc(0, 1, 0, 0, 1, 3, 1, mk(1, ST_UP, 0), "ah_start");
        cyc(0, 0, 1, 1, 0, 0, 0, mk(1, ST_IDLE, 0), "ah_abort_hold");

        // hi = lo + 1, two sweeps; abort during DONE has no extra effect
        cyc(0, 1, 0, 0, 9, 10, 2, mk(9, ST_UP, 0), "adj_start");
        nop(mk(10, ST_DOWN, 0), "adj_top1");
        nop(mk(9, ST_UP, 1), "adj_turn");
        nop(mk(10, ST_DOWN, 1), "adj_top2");
        nop(mk(9, ST_DONE, 2), "adj_done");
        cyc(0, 0, 1, 0, 0, 0, 0, mk(9, ST_IDLE, 2), "adj_abort_in_done");

        // Reset mid-sweep with start held high
        cyc(0, 1, 0, 0, 3, 8, 1, mk(3, ST_UP, 0), "rs_start");
        cyc(0, 1, 0, 0, 3, 8, 1, mk(4, ST_UP, 0), "rs_q4");
        cyc(0, 1, 0, 0, 3, 8, 1, mk(5, ST_UP, 0), "rs_q5");
        cyc(1, 1, 0, 0, 3, 8, 1, mk(0, ST_IDLE, 0), "rs_reset");
        cyc(0, 1, 0, 0, 3, 8, 1, mk(3, ST_UP, 0), "rs_restart");
        cyc(0, 0, 1, 0, 0, 0, 0, mk(3, ST_IDLE, 0), "rs_abort");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
